// File: rtl/load_align_unit_if.sv
// load_align_unit_if: memory read port between the load front-end and the data memory.
//   mem_req   : read request, held high until acknowledged (driven by master)
//   mem_addr  : word-aligned read address (driven by master)
//   mem_ack   : acknowledge, mem_rdata valid in the same cycle (driven by slave)
//   mem_rdata : read word (driven by slave)
interface load_align_unit_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: multi-cycle load front-end. Takes a load request (address and
// size), reads the containing word over a req/ack port, extracts the addressed
// byte/half/word right-justified and zero-filled, and reports the extension mode
// for the downstream sign-extender. Rejects misaligned/illegal requests and
// aborts on memory timeout.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   ld_start         : load request (sampled only when idle)
//   ld_addr, ld_size : byte address; size 0=word 1=half 2=byte 3=illegal
//   ld_busy          : high whenever not idle
//   ld_done          : one-cycle pulse, ld_data/ld_sem_ctrl valid
//   ld_data          : extracted data, right-justified, zero-filled
//   ld_sem_ctrl      : 0=pass, 1=sign-extend 16, 2=sign-extend 8
//   ld_err           : one-cycle abort pulse
//   ld_err_code      : 1=misaligned 2=illegal size 3=timeout (held)
//   mem              : memory read port (master side)
module load_align_unit #(
   parameter bit BIG_ENDIAN     = 1'b1,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_start,
   input  logic [31:0]               ld_addr,
   input  logic [1:0]                ld_size,
   output logic                      ld_busy,
   output logic                      ld_done,
   output logic [31:0]               ld_data,
   output logic [1:0]                ld_sem_ctrl,
   output logic                      ld_err,
   output logic [1:0]                ld_err_code,
   load_align_unit_if.master         mem
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  sem_q, sem_d;
   logic [1:0]  code_q, code_d;

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] extracted;

   // Right-shift amount that brings the addressed lane down to bit 0.
   // Big-endian offset n lives at the top, so the shift is the complement.
   always_comb begin
      shamt = 5'd0;
      case (size_q)
         2'd1:    shamt = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
         2'd2:    shamt = BIG_ENDIAN ? {~off_q, 3'b000}     : {off_q, 3'b000};
         default: shamt = 5'd0;
      endcase
   end

   assign shifted = mem.mem_rdata >> shamt;

   always_comb begin
      extracted = shifted;
      case (size_q)
         2'd1:    extracted = {16'h0000, shifted[15:0]};
         2'd2:    extracted = {24'h000000, shifted[7:0]};
         default: extracted = shifted;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      off_d      = off_q;
      size_d     = size_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      data_d     = data_q;
      sem_d      = sem_q;
      code_d     = code_q;
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               off_d  = ld_addr[1:0];
               size_d = ld_size;
               if (ld_size == 2'd3) begin
                  state_d = S_ERR;
                  code_d  = 2'd2;
               end else if ((ld_size == 2'd1 && ld_addr[0]) ||
                            (ld_size == 2'd0 && ld_addr[1:0] != 2'd0)) begin
                  state_d = S_ERR;
                  code_d  = 2'd1;
               end else begin
                  state_d    = S_REQ;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {ld_addr[31:2], 2'b00};
                  cnt_d      = 8'd0;
               end
            end
         end
         S_REQ: begin
            // An ack in the timeout cycle still completes the load.
            if (mem.mem_ack) begin
               data_d    = extracted;
               sem_d     = size_q;   // size encoding doubles as extension mode
               mem_req_d = 1'b0;
               state_d   = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               mem_req_d = 1'b0;
               code_d    = 2'd3;
               state_d   = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;   // DONE/ERR last exactly one cycle
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         off_q      <= 2'd0;
         size_q     <= 2'd0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
         data_q     <= 32'd0;
         sem_q      <= 2'd0;
         code_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         size_q     <= size_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         data_q     <= data_d;
         sem_q      <= sem_d;
         code_q     <= code_d;
      end
   end

   assign ld_busy      = (state_q != S_IDLE);
   assign ld_done      = (state_q == S_DONE);
   assign ld_err       = (state_q == S_ERR);
   assign ld_data      = data_q;
   assign ld_sem_ctrl  = sem_q;
   assign ld_err_code  = code_q;
   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a big-endian and a little-endian instance see the
// same load requests and the same memory responses; expected results come from a
// byte-addressed view of the memory word.
module tb_load_align_unit;

   localparam int TO = 15;

   logic        clk;
   logic        rst;
   logic        ld_start;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;

   logic        busy [2];
   logic        done [2];
   logic [31:0] data [2];
   logic [1:0]  sem  [2];
   logic        err  [2];
   logic [1:0]  code [2];
   logic        mreq [2];
   logic [31:0] maddr[2];

   int checks;
   int failures;

   load_align_unit_if mif0 ();
   load_align_unit_if mif1 ();

   load_align_unit #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(TO)) dut_be (
      .clk(clk), .rst(rst), .ld_start(ld_start), .ld_addr(ld_addr), .ld_size(ld_size),
      .ld_busy(busy[0]), .ld_done(done[0]), .ld_data(data[0]), .ld_sem_ctrl(sem[0]),
      .ld_err(err[0]), .ld_err_code(code[0]), .mem(mif0.master));

   load_align_unit #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(TO)) dut_le (
      .clk(clk), .rst(rst), .ld_start(ld_start), .ld_addr(ld_addr), .ld_size(ld_size),
      .ld_busy(busy[1]), .ld_done(done[1]), .ld_data(data[1]), .ld_sem_ctrl(sem[1]),
      .ld_err(err[1]), .ld_err_code(code[1]), .mem(mif1.master));

   assign mreq[0]  = mif0.mem_req;
   assign mreq[1]  = mif1.mem_req;
   assign maddr[0] = mif0.mem_addr;
   assign maddr[1] = mif1.mem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ack(input logic a);
      mif0.mem_ack = a;
      mif1.mem_ack = a;
   endtask

   task automatic set_rdata(input logic [31:0] w);
      mif0.mem_rdata = w;
      mif1.mem_rdata = w;
   endtask

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   // Reference: split the word into memory bytes by address, then assemble the
   // accessed bytes with the lowest address most significant (BE) or least (LE).
   function automatic logic [31:0] model(input int be, input logic [1:0] off,
                                         input logic [1:0] size, input logic [31:0] w);
      logic [7:0] b [4];
      int o;
      o = int'(off);
      for (int i = 0; i < 4; i++)
         b[i] = be ? w[31-8*i -: 8] : w[8*i +: 8];
      case (size)
         2'd0:    model = be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
         2'd1:    model = be ? {16'h0, b[o], b[o+1]} : {16'h0, b[o+1], b[o]};
         default: model = {24'h0, b[o]};
      endcase
   endfunction

   // Issue one load and follow it to completion. ack_cyc = REQ cycle carrying
   // the ack (1 = first REQ cycle), 0 = memory never answers.
   task automatic run_load(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] rdata, input int ack_cyc, input bit hold_start);
      int ecode;
      ecode = 0;
      if (size == 2'd3) ecode = 2;
      else if ((size == 2'd1 && addr[0]) || (size == 2'd0 && addr[1:0] != 2'd0)) ecode = 1;
      ld_start = 1'b1;
      ld_addr  = addr;
      ld_size  = size;
      set_rdata(rdata);
      tick();
      if (!hold_start) ld_start = 1'b0;
      if (ecode != 0) begin
         for (int d = 0; d < 2; d++) begin
            chk("rej_err", d, 32'(err[d]), 32'd1);
            chk("rej_code", d, 32'(code[d]), 32'(ecode));
            chk("rej_mreq", d, 32'(mreq[d]), 32'd0);
            chk("rej_busy", d, 32'(busy[d]), 32'd1);
         end
         ld_start = 1'b0;
         tick();
         for (int d = 0; d < 2; d++) begin
            chk("rej_idle_busy", d, 32'(busy[d]), 32'd0);
            chk("rej_idle_err", d, 32'(err[d]), 32'd0);
            chk("rej_idle_mreq", d, 32'(mreq[d]), 32'd0);
         end
         return;
      end
      for (int c = 1; c <= TO; c++) begin
         for (int d = 0; d < 2; d++) begin
            chk("req_mreq", d, 32'(mreq[d]), 32'd1);
            chk("req_addr", d, maddr[d], {addr[31:2], 2'b00});
            chk("req_busy", d, 32'(busy[d]), 32'd1);
            chk("req_done", d, 32'(done[d]), 32'd0);
         end
         if (c == ack_cyc) begin
            set_ack(1'b1);
            ld_start = 1'b0;
            tick();
            set_ack(1'b0);
            for (int d = 0; d < 2; d++) begin
               chk("done_pulse", d, 32'(done[d]), 32'd1);
               chk("done_data", d, data[d], model(d == 0 ? 1 : 0, addr[1:0], size, rdata));
               chk("done_sem", d, 32'(sem[d]), 32'(size));
               chk("done_mreq", d, 32'(mreq[d]), 32'd0);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
               chk("after_done", d, 32'(done[d]), 32'd0);
               chk("after_busy", d, 32'(busy[d]), 32'd0);
            end
            return;
         end
         tick();
      end
      ld_start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("to_err", d, 32'(err[d]), 32'd1);
         chk("to_code", d, 32'(code[d]), 32'd3);
         chk("to_mreq", d, 32'(mreq[d]), 32'd0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("to_idle_err", d, 32'(err[d]), 32'd0);
         chk("to_idle_busy", d, 32'(busy[d]), 32'd0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      ld_start = 1'b0;
      ld_addr  = 32'd0;
      ld_size  = 2'd0;
      set_ack(1'b0);
      set_rdata(32'd0);
      tick();
      set_ack(1'b1);
      tick();
      set_ack(1'b0);
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", d, 32'(busy[d]), 32'd0);
         chk("rst_done", d, 32'(done[d]), 32'd0);
         chk("rst_err", d, 32'(err[d]), 32'd0);
         chk("rst_mreq", d, 32'(mreq[d]), 32'd0);
         chk("rst_data", d, data[d], 32'd0);
         chk("rst_maddr", d, maddr[d], 32'd0);
         chk("rst_sem", d, 32'(sem[d]), 32'd0);
         chk("rst_code", d, 32'(code[d]), 32'd0);
      end
      rst = 1'b0;
      tick();
      // stray ack while idle
      set_ack(1'b1);
      tick();
      set_ack(1'b0);
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("idle_ack_done", d, 32'(done[d]), 32'd0);
         chk("idle_ack_busy", d, 32'(busy[d]), 32'd0);
      end

      // byte at 0x1003, ack one cycle after req
      run_load(32'h0000_1003, 2'd2, 32'h1122_3384, 2, 1'b0);
      chk("tp1_data", 0, data[0], 32'h0000_0084);
      // half at 0x2002, ack in first REQ cycle
      run_load(32'h0000_2002, 2'd1, 32'hAAAA_8001, 1, 1'b0);
      chk("tp2_data", 0, data[0], 32'h0000_8001);
      // misaligned word, then illegal size
      run_load(32'h0000_2001, 2'd0, 32'h0, 1, 1'b0);
      run_load(32'h0000_2000, 2'd3, 32'h0, 1, 1'b0);
      // error code persists across a successful load
      run_load(32'h0000_2004, 2'd0, 32'hDEAD_BEEF, 3, 1'b0);
      chk("code_hold", 0, 32'(code[0]), 32'd2);
      chk("word_data", 1, data[1], 32'hDEAD_BEEF);
      // timeout, then a late ack is ignored
      run_load(32'h0000_3000, 2'd0, 32'h1234_5678, 0, 1'b0);
      set_ack(1'b1);
      tick();
      set_ack(1'b0);
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("late_ack_done", d, 32'(done[d]), 32'd0);
         chk("late_ack_busy", d, 32'(busy[d]), 32'd0);
         chk("late_ack_data", d, data[d], 32'hDEAD_BEEF);
      end
      // LE byte at 0x4001 with a second start held during REQ
      run_load(32'h0000_4001, 2'd2, 32'h1122_3344, 3, 1'b1);
      chk("tp6_le_data", 1, data[1], 32'h0000_0033);

      // reset in the third REQ cycle
      ld_start = 1'b1;
      ld_addr  = 32'h0000_5000;
      ld_size  = 2'd0;
      tick();
      ld_start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("midrst_mreq", d, 32'(mreq[d]), 32'd0);
         chk("midrst_busy", d, 32'(busy[d]), 32'd0);
         chk("midrst_data", d, data[d], 32'd0);
      end
      set_ack(1'b1);
      tick();
      tick();
      set_ack(1'b0);
      for (int d = 0; d < 2; d++) begin
         chk("midrst_ack_done", d, 32'(done[d]), 32'd0);
         chk("midrst_ack_busy", d, 32'(busy[d]), 32'd0);
      end

      // randomized loads, back to back
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         logic [1:0]  s;
         a = $urandom;
         s = 2'($urandom_range(0, 3));
         if (s != 2'd3 && $urandom_range(0, 3) != 0) begin
            if (s == 2'd0) a[1:0] = 2'd0;
            if (s == 2'd1) a[0] = 1'b0;
         end
         run_load(a, s, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Multi-cycle load front-end between the data-memory port and the datapath's 16/8-bit sign-extension stage.
- Accepts a load request (address and size), then runs a req/ack read of the word-aligned memory address.
- Extracts the addressed byte, halfword or word, right-justifies it and zero-fills it.
- Emits the matching 2-bit extension-mode code, so the downstream extender produces the lb/lh/lw result.
- Detects misaligned or illegal requests and memory timeouts.

Parameters:
- BIG_ENDIAN, 1, 1 = MIPS big-endian lane order (offset 0 = bits 31:24); 0 = little-endian (offset 0 = bits 7:0).
- TIMEOUT_CYCLES, 15, maximum cycles the unit waits for mem_ack in REQ before aborting; legal range 1..255.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous, active-high reset
- ld_start  in  1  load request; sampled only in IDLE
- ld_addr  in  32  byte address of the load
- ld_size  in  2  0 = word, 1 = half, 2 = byte, 3 = illegal
- ld_busy  out  1  high in every state other than IDLE
- ld_done  out  1  one-cycle pulse; ld_data and ld_sem_ctrl are valid
- ld_data  out  32  extracted data, right-justified, upper bits zero
- ld_sem_ctrl  out  2  extension mode for downstream: 0 = pass (word), 1 = sign-extend 16, 2 = sign-extend 8
- ld_err  out  1  one-cycle pulse; load aborted
- ld_err_code  out  2  1 = misaligned, 2 = illegal size, 3 = timeout; held until next ld_err
- mem_req  out  1  memory read request (registered)
- mem_addr  out  32  {ld_addr[31:2], 2'b00}
- mem_ack  in  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read word

Behaviour:
- Reset: synchronous, active-high, and overrides everything including a mid-load.
- Values after a reset edge: FSM = IDLE; ld_busy, ld_done, ld_err, mem_req = 0; ld_data, mem_addr = 0; ld_sem_ctrl, ld_err_code = 0; timeout counter = 0.
- A mem_ack arriving after reset or while in IDLE is ignored.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE, ld_start = 1: latch ld_addr[1:0] and ld_size, then check the request:
  - size 3 -> ERR with code 2.
  - half with addr[0] = 1, or word with addr[1:0] != 0 -> ERR with code 1.
  - Otherwise -> REQ; mem_req = 1 and mem_addr set on the same edge; counter cleared.
- ld_start in any state other than IDLE is ignored (no queueing).
- REQ: mem_req held high and mem_addr held stable.
  - mem_ack = 1: capture mem_rdata, drop mem_req, go to DONE.
  - Otherwise the counter increments; when the counter equals TIMEOUT_CYCLES-1 without an ack -> drop mem_req, go to ERR with code 3.
  - An ack in the same cycle as the timeout condition wins (goes to DONE).
- DONE: ld_done = 1 for exactly one cycle, then IDLE. ld_data and ld_sem_ctrl hold until the next DONE.
- ERR: ld_err = 1 for one cycle, then IDLE. ld_data is unchanged.
- Lane select for big-endian (BIG_ENDIAN = 1):
  - byte offset n -> bits [31-8n : 24-8n].
  - half offset 0 -> [31:16]; half offset 2 -> [15:0].
- Little-endian mirrors this: byte n -> [8n+7 : 8n]; half offset 0 -> [15:0]; half offset 2 -> [31:16].
- ld_sem_ctrl mapping: word -> 0, half -> 1, byte -> 2.
- Latency: start sampled at edge 0; mem_req high at cycle 1. If ack is present at cycle k (k ≥ 1), ld_done is high at cycle k+1. Minimum start-to-done latency is 2 cycles.
- Misaligned or illegal requests: ld_err is high at cycle 1 and no memory access is made.
- Back-to-back: a new ld_start is accepted in the cycle after DONE/ERR, i.e. once back in IDLE; ld_busy is already low in that cycle.

Test Plan:
- Reset, then ld_start, addr 0x0000_1003, size 2, BIG_ENDIAN = 1, memory acks 1 cycle after req with 0x1122_3384 -> mem_addr = 0x1000; ld_done at cycle 3; ld_data = 0x0000_0084; ld_sem_ctrl = 2.
- Half load, addr 0x2002, ack in first REQ cycle with 0xAAAA_8001 -> ld_done at cycle 2; ld_data = 0x0000_8001; ld_sem_ctrl = 1.
- Word load, addr 0x2001 -> ld_err at cycle 1, ld_err_code = 1, mem_req never asserted. Then size 3 at addr 0x2000 -> ld_err_code = 2.
- Word load, addr 0x3000, no ack, TIMEOUT_CYCLES = 15 -> mem_req high for exactly 15 cycles, then ld_err with code 3. A later ack is ignored and ld_busy = 0.
- Rst asserted in the 3rd REQ cycle -> next cycle mem_req = 0 and ld_busy = 0. An ack arriving afterwards produces no ld_done.
- BIG_ENDIAN = 0, byte load addr 0x4001, rdata 0x1122_3344 -> ld_data = 0x0000_0033. A second ld_start issued during REQ is ignored; exactly one ld_done occurs.
